// File: rtl/tk2_inv.sv
// Backward-running byte-serial TK2 tweakey schedule for the SKINNY-128 inverse rounds.
// Optional TK2_INV_SKIP_FWD_EN adds ki_final: loaded key is already the last round's TK2.
module tk2_inv #(
  parameter int unsigned NR = 56,
  parameter int unsigned RW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    ki,
  input  logic          ki_valid,
  output logic          ki_ready,
  input  logic          start,
`ifdef TK2_INV_SKIP_FWD_EN
  input  logic          ki_final,
`endif
  output logic [7:0]    ko,
  output logic          ko_valid,
  input  logic          ko_ready,
  output logic          ko_last,
  output logic [RW-1:0] ko_round,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StFwd, StOut} state_e;

  localparam logic [RW-1:0] RndLast  = RW'(NR - 1);
  localparam logic [RW-1:0] FwdLast  = RW'((NR > 1) ? NR - 2 : 0);
  localparam bit            OneRound = (NR == 1);

  localparam logic [3:0] Pt [16] = '{
    4'd9, 4'd15, 4'd8, 4'd13, 4'd10, 4'd14, 4'd12, 4'd11,
    4'd0, 4'd1,  4'd2, 4'd3,  4'd4,  4'd5,  4'd6,  4'd7
  };
  localparam logic [3:0] PtInv [16] = '{
    4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15,
    4'd2, 4'd0, 4'd4,  4'd7,  4'd6,  4'd3,  4'd5,  4'd1
  };

  function automatic logic [7:0] lfsr_fwd(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5]};
  endfunction

  function automatic logic [7:0] lfsr_inv(input logic [7:0] y);
    return {y[0] ^ y[6], y[7:1]};
  endfunction

  function automatic logic [15:0][7:0] step_fwd(input logic [15:0][7:0] c);
    logic [15:0][7:0] n;
    for (int i = 0; i < 16; i++) n[i] = c[Pt[i]];
    for (int i = 0; i < 8; i++) n[i] = lfsr_fwd(n[i]);
    return n;
  endfunction

  // LFSR inverse first, then the inverse permutation.
  function automatic logic [15:0][7:0] step_inv(input logic [15:0][7:0] c);
    logic [15:0][7:0] y;
    logic [15:0][7:0] o;
    y = c;
    for (int i = 0; i < 8; i++) y[i] = lfsr_inv(c[i]);
    for (int k = 0; k < 16; k++) o[k] = y[PtInv[k]];
    return o;
  endfunction

  state_e           state_q;
  logic [15:0][7:0] cells_q;
  logic [4:0]       load_cnt_q;
  logic [2:0]       ptr_q;
  logic [RW-1:0]    rnd_q;
  logic [RW-1:0]    fwd_cnt_q;
  logic             done_q;

  logic start_ok;
  logic ki_take;
  logic ko_take;
  logic skip_fwd;

`ifdef TK2_INV_SKIP_FWD_EN
  assign skip_fwd = OneRound || ki_final;
`else
  assign skip_fwd = OneRound;
`endif

  assign ki_ready = (state_q == StIdle) && !start;
  assign start_ok = (state_q == StIdle) && start && (load_cnt_q == 5'd16);
  assign ki_take  = ki_valid && ki_ready;
  assign ko_valid = (state_q == StOut);
  assign ko_take  = ko_valid && ko_ready;
  assign ko       = ko_valid ? cells_q[ptr_q] : 8'h00;
  assign ko_last  = ko_valid && (ptr_q == 3'd7);
  assign ko_round = rnd_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cells_q    <= '0;
      load_cnt_q <= '0;
      ptr_q      <= '0;
      rnd_q      <= '0;
      fwd_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            rnd_q     <= RndLast;
            ptr_q     <= '0;
            fwd_cnt_q <= '0;
            state_q   <= skip_fwd ? StOut : StFwd;
          end else if (ki_take) begin
            cells_q <= {ki, cells_q[15:1]};
            if (load_cnt_q != 5'd16) load_cnt_q <= load_cnt_q + 5'd1;
          end
        end
        StFwd: begin
          cells_q   <= step_fwd(cells_q);
          fwd_cnt_q <= fwd_cnt_q + 1'b1;
          if (fwd_cnt_q == FwdLast) state_q <= StOut;
        end
        StOut: begin
          if (ko_take) begin
            if (ptr_q == 3'd7) begin
              ptr_q <= '0;
              if (rnd_q != '0) begin
                cells_q <= step_inv(cells_q);
                rnd_q   <= rnd_q - 1'b1;
              end else begin
                // Cells already hold TK_0 again, so a later start replays the same stream.
                state_q <= StIdle;
                done_q  <= 1'b1;
              end
            end else begin
              ptr_q <= ptr_q + 3'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
